data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_pkg.sv | 18 +
 rtl/rr_pick2.sv | 23 ++
 rtl/data_mem_arbiter.sv | 135 +++++++++++++
 tb/tb_data_mem_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory arbiter.
//   DEF_DATA_SIZE    : default data word width (matches the data memory)
//   DEF_ADDRESS_SIZE : default word address width (matches the data memory)
//   WW_WIDTH         : width of a write-width code
//   arb_state_t      : arbiter FSM state encoding
package data_mem_pkg;

  localparam int DEF_DATA_SIZE    = 64;
  localparam int DEF_ADDRESS_SIZE = 11;
  localparam int WW_WIDTH         = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin winner selection (combinational).
//   stb   : request strobes, bit 0 = eBPF core LSU, bit 1 = host port
//   last  : index of the requester served most recently
//   valid : at least one request present
//   pick  : index of the winner (meaningful only when valid)
module rr_pick2 (
  input  logic [1:0] stb,
  input  logic       last,
  output logic       valid,
  output logic       pick
);

  always_comb begin
    valid = |stb;
    pick  = 1'b0;
    case (stb)
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last;   // tie: whoever was not served last
      default: pick = 1'b0;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates two requesters (eBPF core LSU, host port) onto one data memory.
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_stb      : per-requester request strobe (bit 0 LSU, bit 1 host)
//   req_adr      : per-requester word address, slice i = [i*ADDRESS_SIZE +: ADDRESS_SIZE]
//   req_we       : per-requester write enable
//   req_ww       : per-requester write width, slice i = [4i +: 4]
//   req_dat_w    : per-requester write data
//   req_dat_r    : shared read data, valid in the req_ack cycle
//   req_ack      : one-cycle completion pulse per requester
//   req_err      : one-cycle timeout pulse per requester
//   mem_stb      : memory strobe, high throughout ACCESS
//   mem_we       : memory write enable, only ever high in ACCESS
//   mem_adr, mem_ww, mem_dat_w : latched transaction fields
//   mem_dat_r, mem_ack : memory read data and acknowledge
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int DATA_SIZE    = DEF_DATA_SIZE,
  parameter int ADDRESS_SIZE = DEF_ADDRESS_SIZE,
  parameter int TIMEOUT      = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                req_stb,
  input  logic [2*ADDRESS_SIZE-1:0] req_adr,
  input  logic [1:0]                req_we,
  input  logic [2*WW_WIDTH-1:0]     req_ww,
  input  logic [2*DATA_SIZE-1:0]    req_dat_w,
  output logic [DATA_SIZE-1:0]      req_dat_r,
  output logic [1:0]                req_ack,
  output logic [1:0]                req_err,
  output logic                      mem_stb,
  output logic                      mem_we,
  output logic [ADDRESS_SIZE-1:0]   mem_adr,
  output logic [WW_WIDTH-1:0]       mem_ww,
  output logic [DATA_SIZE-1:0]      mem_dat_w,
  input  logic [DATA_SIZE-1:0]      mem_dat_r,
  input  logic                      mem_ack
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  arb_state_t              state;
  logic                    gnt;
  logic                    last;
  logic                    we_q;
  logic [ADDRESS_SIZE-1:0] adr_q;
  logic [WW_WIDTH-1:0]     ww_q;
  logic [DATA_SIZE-1:0]    dat_q;
  logic [CNT_W-1:0]        cnt;

  logic                    pick_valid;
  logic                    pick;

  rr_pick2 u_pick (
    .stb   (req_stb),
    .last  (last),
    .valid (pick_valid),
    .pick  (pick)
  );

  // Winner's fields, muxed by the combinational pick.
  logic [ADDRESS_SIZE-1:0] sel_adr;
  logic [WW_WIDTH-1:0]     sel_ww;
  logic [DATA_SIZE-1:0]    sel_dat;
  logic                    sel_we;

  always_comb begin
    sel_adr = pick ? req_adr[2*ADDRESS_SIZE-1:ADDRESS_SIZE] : req_adr[ADDRESS_SIZE-1:0];
    sel_ww  = pick ? req_ww[2*WW_WIDTH-1:WW_WIDTH]          : req_ww[WW_WIDTH-1:0];
    sel_dat = pick ? req_dat_w[2*DATA_SIZE-1:DATA_SIZE]     : req_dat_w[DATA_SIZE-1:0];
    sel_we  = pick ? req_we[1]                              : req_we[0];
  end

  // Strobe and write enable decode straight from the state register so that
  // an asynchronous reset removes them without waiting for a clock edge.
  assign mem_stb   = (state == ST_ACCESS);
  assign mem_we    = we_q & (state == ST_ACCESS);
  assign mem_adr   = adr_q;
  assign mem_ww    = ww_q;
  assign mem_dat_w = dat_q;

  // req_ack/req_err are loaded on the edge that enters RESP, so they are
  // visible for exactly the RESP cycle and cleared on the edge that leaves it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      gnt       <= 1'b0;
      last      <= 1'b1;
      we_q      <= 1'b0;
      adr_q     <= '0;
      ww_q      <= '0;
      dat_q     <= '0;
      cnt       <= '0;
      req_dat_r <= '0;
      req_ack   <= '0;
      req_err   <= '0;
    end else begin
      req_ack <= '0;
      req_err <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt   <= pick;
            we_q  <= sel_we;
            adr_q <= sel_adr;
            ww_q  <= sel_ww;
            dat_q <= sel_dat;
            cnt   <= '0;
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            if (!we_q) req_dat_r <= mem_dat_r;
            req_ack <= gnt ? 2'b10 : 2'b01;
            state   <= ST_RESP;
          end else if (cnt == TIMEOUT_C) begin
            req_err <= gnt ? 2'b10 : 2'b01;
            state   <= ST_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          last  <= gnt;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_stb;
  logic [21:0]  req_adr;
  logic [1:0]   req_we;
  logic [7:0]   req_ww;
  logic [127:0] req_dat_w;
  logic [63:0]  req_dat_r;
  logic [1:0]   req_ack;
  logic [1:0]   req_err;
  logic         mem_stb;
  logic         mem_we;
  logic [10:0]  mem_adr;
  logic [3:0]   mem_ww;
  logic [63:0]  mem_dat_w;
  logic [63:0]  mem_dat_r;
  logic         mem_ack;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .DATA_SIZE    (64),
    .ADDRESS_SIZE (11),
    .TIMEOUT      (15)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_stb   (req_stb),
    .req_adr   (req_adr),
    .req_we    (req_we),
    .req_ww    (req_ww),
    .req_dat_w (req_dat_w),
    .req_dat_r (req_dat_r),
    .req_ack   (req_ack),
    .req_err   (req_err),
    .mem_stb   (mem_stb),
    .mem_we    (mem_we),
    .mem_adr   (mem_adr),
    .mem_ww    (mem_ww),
    .mem_dat_w (mem_dat_w),
    .mem_dat_r (mem_dat_r),
    .mem_ack   (mem_ack)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  stb;
    logic [1:0]  we;
    logic [10:0] adr0;
    logic [10:0] adr1;
    logic [7:0]  ww;
    logic [63:0] dat0;
    logic [63:0] dat1;
    int          delay;   // ACCESS cycles before mem_ack; -1 = never
    logic [63:0] rdata;
    int          gnt;
    logic [1:0]  ack;
    logic [1:0]  err;
    int          cyc;     // cycle of ack/err, counting the IDLE sample cycle as 0
    logic [63:0] dat_r;
  } vec_t;

  // One transaction from IDLE. Inputs set at a falling edge (cycle 0), outputs
  // observed at each following falling edge. The memory acks in ACCESS cycle
  // delay+1. Live request fields are inverted after the first ACCESS cycle to
  // show the memory side only sees latched values.
  task automatic run_txn(input vec_t v,
                         output logic [1:0] got_ack, output logic [1:0] got_err,
                         output int got_cyc, output logic [63:0] got_dat,
                         output int stb_cyc, output int field_errs,
                         output int we_errs, output int onehot_errs);
    int acc;
    int g;
    g = v.gnt;
    acc = 0; got_ack = '0; got_err = '0; got_cyc = -1; got_dat = '0;
    stb_cyc = -1; field_errs = 0; we_errs = 0; onehot_errs = 0;
    @(negedge clk);
    req_stb   = v.stb;
    req_we    = v.we;
    req_adr   = {v.adr1, v.adr0};
    req_ww    = v.ww;
    req_dat_w = {v.dat1, v.dat0};
    mem_dat_r = v.rdata;
    mem_ack   = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if ((req_ack & req_err) != 2'b00 || req_ack == 2'b11 || req_err == 2'b11)
        onehot_errs++;
      if (mem_we && !mem_stb) we_errs++;
      if (mem_stb) begin
        acc++;
        if (stb_cyc < 0) stb_cyc = k;
        if (mem_adr !== (g == 1 ? v.adr1 : v.adr0)) field_errs++;
        if (mem_ww !== (g == 1 ? v.ww[7:4] : v.ww[3:0])) field_errs++;
        if (mem_dat_w !== (g == 1 ? v.dat1 : v.dat0)) field_errs++;
        if (mem_we !== v.we[g]) we_errs++;
        if (acc == 1) begin
          req_adr   = ~req_adr;
          req_ww    = ~req_ww;
          req_dat_w = ~req_dat_w;
        end
      end
      mem_ack = mem_stb && (acc == v.delay + 1);
      if (req_ack != 2'b00 || req_err != 2'b00) begin
        got_ack = req_ack;
        got_err = req_err;
        got_cyc = k;
        got_dat = req_dat_r;
        req_stb = 2'b00;
        mem_ack = 1'b0;
        break;
      end
    end
    req_stb = 2'b00;
    mem_ack = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    logic [1:0]  ga, ge;
    logic [63:0] gd;
    int gc, sc, fe, we_e, oh;
    int n_acks, last_ack_cyc, rr_ov, quiet;
    int order[4];

    // stb   we     adr0     adr1     ww     dat0                   dat1          delay rdata                  gnt ack    err    cyc dat_r
    vecs[0] = '{2'b01, 2'b00, 11'h010, 11'h7AB, 8'h00, 64'h0,                 64'h0,        0,  64'h0000_0000_DEAD_BEEF, 0, 2'b01, 2'b00, 2,  64'h0000_0000_DEAD_BEEF};
    vecs[1] = '{2'b10, 2'b10, 11'h001, 11'h7FF, 8'h30, 64'h5555,              64'h1234,     3,  64'h0BAD,                1, 2'b10, 2'b00, 5,  64'h0000_0000_DEAD_BEEF};
    vecs[2] = '{2'b10, 2'b00, 11'h000, 11'h055, 8'h00, 64'h0,                 64'h0,        1,  64'h0123_4567_89AB_CDEF, 1, 2'b10, 2'b00, 3,  64'h0123_4567_89AB_CDEF};
    vecs[3] = '{2'b01, 2'b01, 11'h3C0, 11'h000, 8'h0F, 64'hCAFE_F00D_0000_0001, 64'h0,      2,  64'hFFFF,                0, 2'b01, 2'b00, 4,  64'h0123_4567_89AB_CDEF};
    vecs[4] = '{2'b01, 2'b01, 11'h020, 11'h000, 8'h05, 64'h9999,              64'h0,        -1, 64'h1111,                0, 2'b00, 2'b01, 17, 64'h0123_4567_89AB_CDEF};
    vecs[5] = '{2'b10, 2'b00, 11'h000, 11'h021, 8'h00, 64'h0,                 64'h0,        15, 64'hA5A5_5A5A_0F0F_F0F0, 1, 2'b10, 2'b00, 17, 64'hA5A5_5A5A_0F0F_F0F0};
    vecs[6] = '{2'b11, 2'b00, 11'h111, 11'h222, 8'h00, 64'h0,                 64'h0,        0,  64'h77,                  0, 2'b01, 2'b00, 2,  64'h77};

    rst_n = 1'b0; req_stb = '0; req_adr = '0; req_we = '0; req_ww = '0;
    req_dat_w = '0; mem_dat_r = '0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_stb", mem_stb, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_req_ack", req_ack, 0);
    chk("rst_req_err", req_err, 0);
    chk("rst_req_dat_r", req_dat_r, 0);
    chk("rst_mem_adr", mem_adr, 0);
    chk("rst_mem_dat_w", mem_dat_w, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i], ga, ge, gc, gd, sc, fe, we_e, oh);
      chk($sformatf("v%0d_ack", i), ga, vecs[i].ack);
      chk($sformatf("v%0d_err", i), ge, vecs[i].err);
      chk($sformatf("v%0d_cycle", i), gc, vecs[i].cyc);
      chk($sformatf("v%0d_dat_r", i), gd, vecs[i].dat_r);
      chk($sformatf("v%0d_stb_cycle", i), sc, 1);
      chk($sformatf("v%0d_field_errs", i), fe, 0);
      chk($sformatf("v%0d_we_errs", i), we_e, 0);
      chk($sformatf("v%0d_onehot_errs", i), oh, 0);
    end

    // Reset in the middle of a write: strobe and write enable must fall with
    // no clock edge, no ack follows, and arbitration history returns to reset.
    @(negedge clk);
    req_stb = 2'b10; req_we = 2'b10; req_adr = {11'h3AA, 11'h000};
    req_ww = 8'hF0; req_dat_w = {64'h1234_5678, 64'h0}; mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_pre_stb", mem_stb, 1);
    chk("rstmid_pre_we", mem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_stb", mem_stb, 0);
    chk("rstmid_we", mem_we, 0);
    chk("rstmid_adr", mem_adr, 0);
    req_stb = 2'b00;
    quiet = 0;
    repeat (2) begin
      @(negedge clk);
      if (req_ack != 2'b00 || req_err != 2'b00 || mem_stb) quiet++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (req_ack != 2'b00 || req_err != 2'b00 || mem_stb) quiet++;
    end
    chk("rstmid_no_activity", quiet, 0);

    // Both requesters hold stb: grants alternate starting with requester 0.
    @(negedge clk);
    req_stb = 2'b11; req_we = 2'b00; req_adr = {11'h200, 11'h100};
    mem_dat_r = 64'h5A; mem_ack = 1'b0;
    n_acks = 0; last_ack_cyc = -1; rr_ov = 0;
    for (int i = 0; i < 4; i++) order[i] = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if ((req_ack & req_err) != 2'b00 || req_ack == 2'b11 || req_err == 2'b11 || req_err != 2'b00)
        rr_ov++;
      if (req_ack != 2'b00) begin
        if (n_acks < 4) order[n_acks] = (req_ack == 2'b10) ? 1 : (req_ack == 2'b01) ? 0 : 3;
        n_acks++;
        last_ack_cyc = k;
        if (n_acks == 4) begin
          req_stb = 2'b00;
          mem_ack = 1'b0;
          break;
        end
      end
      mem_ack = mem_stb;
    end
    req_stb = 2'b00;
    mem_ack = 1'b0;
    chk("rr_ack_count", n_acks, 4);
    chk("rr_grant0", order[0], 0);
    chk("rr_grant1", order[1], 1);
    chk("rr_grant2", order[2], 0);
    chk("rr_grant3", order[3], 1);
    chk("rr_last_ack_cycle", last_ack_cyc, 11);
    chk("rr_overlap_or_err", rr_ov, 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
